// File: rtl/uart_tx_rx_buff2.sv
// ============================================================================
// uart_tx_rx_buff2 : 8N1 UART store-and-forward echo, 4-byte buffer, macro FRAMING_CHECK_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_tx_rx_buff2 #(
   parameter int CLK_FREQ  = 12000000,
   parameter int BAUD      = 9600,
   parameter int IDLE_BITS = 20
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        rx,
   output logic        tx,
   output logic        ready,
   output logic [9:0]  data_store,
   output logic [9:0]  bit_count,
   output logic [3:0]  bit_count2,
   output logic [3:0]  byte_count,
   output logic [3:0]  byte_count2,
   output logic        busy,
   output logic        busy2,
   output logic        idle,
   output logic [4:0]  bit_count3,
   output logic [31:0] data_store2,
   output logic        busy1
);

   localparam int                c_DIV       = CLK_FREQ / (BAUD * 16);
   localparam int                c_PW        = (c_DIV > 1) ? $clog2(c_DIV) : 1;
   localparam logic [c_PW-1:0]   c_DIV_LAST  = c_PW'(c_DIV - 1);
   localparam logic [4:0]        c_IDLE_BITS = 5'(IDLE_BITS);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [0:0] {T_IDLE, T_FRAME} tx_state_t;

   logic [c_PW-1:0] prescale_q, prescale_d;
   logic            rx_meta_q, rx_meta_d;
   logic            rx_sync_q, rx_sync_d;
   rx_state_t       rx_state_q, rx_state_d;
   logic            busy_q, busy_d;
   logic [9:0]      bit_count_q, bit_count_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic [9:0]      data_store_q, data_store_d;
   logic [3:0]      idle_tick_q, idle_tick_d;
   logic [4:0]      bit_count3_q, bit_count3_d;
   tx_state_t       tx_state_q, tx_state_d;
   logic            tx_q, tx_d;
   logic            busy2_q, busy2_d;
   logic [3:0]      bit_count2_q, bit_count2_d;
   logic [3:0]      tx_tick_q, tx_tick_d;
   logic [7:0]      tx_byte_q, tx_byte_d;
   logic            busy1_q, busy1_d;
   logic [3:0]      byte_count_q, byte_count_d;
   logic [3:0]      byte_count2_q, byte_count2_d;
   logic [31:0]     data_store2_q, data_store2_d;
   logic            ready_q, ready_d;

   logic            w_tick;
   logic [9:0]      w_cnt_inc;
   logic            w_rx_done;
   logic            w_frame_ok;
   logic            w_tx_done;
   logic            w_flush_trig;
   logic [7:0]      w_cur_byte;

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         prescale_q    <= '0;
         rx_meta_q     <= 1'b1;
         rx_sync_q     <= 1'b1;
         rx_state_q    <= R_IDLE;
         busy_q        <= 1'b0;
         bit_count_q   <= '0;
         rx_data_q     <= '0;
         data_store_q  <= '0;
         idle_tick_q   <= '0;
         bit_count3_q  <= '0;
         tx_state_q    <= T_IDLE;
         tx_q          <= 1'b1;
         busy2_q       <= 1'b0;
         bit_count2_q  <= '0;
         tx_tick_q     <= '0;
         tx_byte_q     <= '0;
         busy1_q       <= 1'b0;
         byte_count_q  <= '0;
         byte_count2_q <= '0;
         data_store2_q <= '0;
         ready_q       <= 1'b0;
      end else begin
         prescale_q    <= prescale_d;
         rx_meta_q     <= rx_meta_d;
         rx_sync_q     <= rx_sync_d;
         rx_state_q    <= rx_state_d;
         busy_q        <= busy_d;
         bit_count_q   <= bit_count_d;
         rx_data_q     <= rx_data_d;
         data_store_q  <= data_store_d;
         idle_tick_q   <= idle_tick_d;
         bit_count3_q  <= bit_count3_d;
         tx_state_q    <= tx_state_d;
         tx_q          <= tx_d;
         busy2_q       <= busy2_d;
         bit_count2_q  <= bit_count2_d;
         tx_tick_q     <= tx_tick_d;
         tx_byte_q     <= tx_byte_d;
         busy1_q       <= busy1_d;
         byte_count_q  <= byte_count_d;
         byte_count2_q <= byte_count2_d;
         data_store2_q <= data_store2_d;
         ready_q       <= ready_d;
      end
   end

   assign w_tick = (prescale_q == c_DIV_LAST);

   always_comb begin
      prescale_d = w_tick ? '0 : prescale_q + c_PW'(1);
      rx_meta_d  = rx;
      rx_sync_d  = rx_meta_q;
   end

   // Receiver: start sampled at tick 8, data every 16 ticks after, stop at 152.
   assign w_cnt_inc = bit_count_q + 10'd1;

   always_comb begin
      rx_state_d   = rx_state_q;
      busy_d       = busy_q;
      bit_count_d  = bit_count_q;
      rx_data_d    = rx_data_q;
      data_store_d = data_store_q;
      w_rx_done    = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            if (w_tick && !rx_sync_q) begin
               rx_state_d  = R_START;
               busy_d      = 1'b1;
               bit_count_d = '0;
            end
         end
         R_START: begin
            if (w_tick) begin
               bit_count_d = w_cnt_inc;
               if (w_cnt_inc == 10'd8) begin
                  if (rx_sync_q) begin
                     rx_state_d = R_IDLE;
                     busy_d     = 1'b0;
                  end else begin
                     rx_state_d = R_DATA;
                  end
               end
            end
         end
         R_DATA: begin
            if (w_tick) begin
               bit_count_d = w_cnt_inc;
               if (w_cnt_inc[3:0] == 4'd8) begin
                  rx_data_d = {rx_sync_q, rx_data_q[7:1]};
                  if (w_cnt_inc == 10'd136) begin
                     rx_state_d = R_STOP;
                  end
               end
            end
         end
         R_STOP: begin
            if (w_tick) begin
               bit_count_d = w_cnt_inc;
               if (w_cnt_inc == 10'd152) begin
                  data_store_d = {rx_sync_q, rx_data_q, 1'b0};
                  rx_state_d   = R_IDLE;
                  busy_d       = 1'b0;
                  w_rx_done    = 1'b1;
               end
            end
         end
         default: begin
            rx_state_d = R_IDLE;
            busy_d     = 1'b0;
         end
      endcase
   end

`ifdef FRAMING_CHECK_EN
   assign w_frame_ok = rx_sync_q;
`else
   assign w_frame_ok = 1'b1;
`endif

   always_comb begin
      idle_tick_d  = idle_tick_q;
      bit_count3_d = bit_count3_q;
      if (busy_q || !rx_sync_q) begin
         idle_tick_d  = '0;
         bit_count3_d = '0;
      end else if (w_tick) begin
         idle_tick_d = idle_tick_q + 4'd1;
         if (idle_tick_q == 4'd15 && bit_count3_q != 5'd31) begin
            bit_count3_d = bit_count3_q + 5'd1;
         end
      end
   end

   assign w_cur_byte = data_store2_q[{byte_count2_q[1:0], 3'b000} +: 8];

   // Frames launch on a tick so every bit spans exactly 16 ticks.
   always_comb begin
      tx_state_d   = tx_state_q;
      tx_d         = tx_q;
      busy2_d      = busy2_q;
      bit_count2_d = bit_count2_q;
      tx_tick_d    = tx_tick_q;
      tx_byte_d    = tx_byte_q;
      w_tx_done    = 1'b0;
      case (tx_state_q)
         T_IDLE: begin
            tx_d    = 1'b1;
            busy2_d = 1'b0;
            if (busy1_q && (byte_count2_q < byte_count_q) && w_tick) begin
               tx_state_d   = T_FRAME;
               tx_d         = 1'b0;
               busy2_d      = 1'b1;
               bit_count2_d = '0;
               tx_tick_d    = '0;
               tx_byte_d    = w_cur_byte;
            end
         end
         T_FRAME: begin
            if (w_tick) begin
               tx_tick_d = tx_tick_q + 4'd1;
               if (tx_tick_q == 4'd15) begin
                  if (bit_count2_q == 4'd9) begin
                     tx_state_d   = T_IDLE;
                     tx_d         = 1'b1;
                     busy2_d      = 1'b0;
                     bit_count2_d = '0;
                     w_tx_done    = 1'b1;
                  end else begin
                     bit_count2_d = bit_count2_q + 4'd1;
                     tx_d         = (bit_count2_q == 4'd8) ? 1'b1 : tx_byte_q[bit_count2_q[2:0]];
                  end
               end
            end
         end
         default: begin
            tx_state_d = T_IDLE;
            tx_d       = 1'b1;
            busy2_d    = 1'b0;
         end
      endcase
   end

   // A flush trigger takes priority over a byte completing on the same clock.
   assign w_flush_trig = !busy1_q && ((byte_count_q == 4'd4) || (idle && byte_count_q != 4'd0));

   always_comb begin
      busy1_d       = busy1_q;
      byte_count_d  = byte_count_q;
      byte_count2_d = byte_count2_q;
      data_store2_d = data_store2_q;
      ready_d       = 1'b0;
      if (busy1_q) begin
         if (w_tx_done) begin
            byte_count2_d = byte_count2_q + 4'd1;
         end
         if (tx_state_q == T_IDLE && byte_count2_q == byte_count_q) begin
            busy1_d       = 1'b0;
            byte_count_d  = '0;
            byte_count2_d = '0;
            data_store2_d = '0;
         end
      end else if (w_flush_trig) begin
         busy1_d       = 1'b1;
         byte_count2_d = '0;
      end else if (w_rx_done && w_frame_ok && byte_count_q < 4'd4) begin
         data_store2_d[{byte_count_q[1:0], 3'b000} +: 8] = rx_data_q;
         byte_count_d = byte_count_q + 4'd1;
         ready_d      = 1'b1;
      end
   end

   assign tx          = tx_q;
   assign ready       = ready_q;
   assign data_store  = data_store_q;
   assign bit_count   = bit_count_q;
   assign bit_count2  = bit_count2_q;
   assign byte_count  = byte_count_q;
   assign byte_count2 = byte_count2_q;
   assign busy        = busy_q;
   assign busy2       = busy2_q;
   assign idle        = (bit_count3_q >= c_IDLE_BITS);
   assign bit_count3  = bit_count3_q;
   assign data_store2 = data_store2_q;
   assign busy1       = busy1_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_rx_buff2.sv
// ============================================================================
// tb_uart_tx_rx_buff2 : directed bench with tx echo scoreboard (macro FRAMING_CHECK_EN aware)
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_rx_buff2;

   localparam int BAUD     = 9600;
   localparam int CLK_FREQ = BAUD * 16 * 6;
   localparam int BIT_CLKS = 16 * 6;

   logic        clk;
   logic        nrst;
   logic        rx;
   logic        tx;
   logic        ready;
   logic [9:0]  data_store;
   logic [9:0]  bit_count;
   logic [3:0]  bit_count2;
   logic [3:0]  byte_count;
   logic [3:0]  byte_count2;
   logic        busy;
   logic        busy2;
   logic        idle;
   logic [4:0]  bit_count3;
   logic [31:0] data_store2;
   logic        busy1;

   uart_tx_rx_buff2 #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .IDLE_BITS (20)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .rx          (rx),
      .tx          (tx),
      .ready       (ready),
      .data_store  (data_store),
      .bit_count   (bit_count),
      .bit_count2  (bit_count2),
      .byte_count  (byte_count),
      .byte_count2 (byte_count2),
      .busy        (busy),
      .busy2       (busy2),
      .idle        (idle),
      .bit_count3  (bit_count3),
      .data_store2 (data_store2),
      .busy1       (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   int         ready_cnt   = 0;
   int         busy_rises  = 0;
   int         busy1_rises = 0;
   int         tx_frames   = 0;
   logic [3:0] bc2_max     = '0;
   logic       busy_prev   = 1'b0;
   logic       busy1_prev  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx = stop_bit;
      repeat (BIT_CLKS) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic wait_busy1(input logic lvl, input int max_clks, input string tag);
      int n = 0;
      while (busy1 !== lvl && n < max_clks) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(busy1), 32'(lvl));
   endtask

   always @(negedge clk) begin
      if (ready === 1'b1) ready_cnt++;
      if (busy === 1'b1 && busy_prev !== 1'b1) busy_rises++;
      if (busy1 === 1'b1 && busy1_prev !== 1'b1) begin
         busy1_rises++;
         bc2_max = '0;
      end
      if (busy1 === 1'b1 && byte_count2 > bc2_max) bc2_max = byte_count2;
      busy_prev  = busy;
      busy1_prev = busy1;
   end

   // Decodes each tx frame at bit centres and checks it against the next expected byte.
   initial begin : tx_monitor
      logic       start_b;
      logic       stop_b;
      logic [7:0] data_b;
      @(negedge nrst);
      forever begin
         @(negedge tx);
         repeat (BIT_CLKS / 2) @(negedge clk);
         start_b = tx;
         for (int i = 0; i < 8; i++) begin
            repeat (BIT_CLKS) @(negedge clk);
            data_b[i] = tx;
         end
         repeat (BIT_CLKS) @(negedge clk);
         stop_b = tx;
         tx_frames++;
         check("tx_start_bit", 32'(start_b), 32'd0);
         check("tx_stop_bit", 32'(stop_b), 32'd1);
         if (exp_q.size() > 0) begin
            check("tx_echo_byte", 32'(data_b), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin : stimulus
      int         r0;
      int         f0;
      int         b0;
      int         s0;
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] quad [4];

      nrst = 1'b1;
      rx   = 1'b1;
      repeat (100) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_counters", 32'({bit_count, bit_count2, byte_count, byte_count2, bit_count3}), 32'd0);
      check("rst_flags", 32'({ready, busy, busy1, busy2, idle}), 32'd0);
      check("rst_data_store", 32'(data_store), 32'd0);
      check("rst_data_store2", data_store2, 32'd0);
      nrst = 1'b0;

      // Idle counter reaches the threshold only after 20 bit-times.
      repeat (19 * BIT_CLKS + 48) @(negedge clk);
      check("idle_count_19", 32'(bit_count3), 32'd19);
      check("idle_low_19", 32'(idle), 32'd0);
      repeat (BIT_CLKS) @(negedge clk);
      check("idle_high_20", 32'(idle), 32'd1);

      // Single byte then idle flush.
      r0 = ready_cnt;
      f0 = tx_frames;
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b1);
      check("a5_ready_pulses", 32'(ready_cnt - r0), 32'd1);
      check("a5_data_store", 32'(data_store), 32'(10'b1_10100101_0));
      check("a5_data_store2", data_store2, 32'h0000_00A5);
      check("a5_byte_count", 32'(byte_count), 32'd1);
      repeat (18 * BIT_CLKS) @(negedge clk);
      check("a5_no_early_flush", 32'(busy1), 32'd0);
      wait_busy1(1'b1, 4 * BIT_CLKS, "a5_flush_start");
      wait_busy1(1'b0, 15 * BIT_CLKS, "a5_flush_end");
      check("a5_byte_count_clr", 32'(byte_count), 32'd0);
      check("a5_data_store2_clr", data_store2, 32'd0);
      check("a5_tx_frames", 32'(tx_frames - f0), 32'd1);

      // Two random bytes with a short gap share one flush.
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      b0 = busy1_rises;
      f0 = tx_frames;
      exp_q.push_back(b1);
      exp_q.push_back(b2);
      send_byte(b1, 1'b1);
      repeat (4 * BIT_CLKS) @(negedge clk);
      check("pair_no_flush_gap", 32'(busy1), 32'd0);
      send_byte(b2, 1'b1);
      check("pair_byte_count", 32'(byte_count), 32'd2);
      check("pair_data_store2", data_store2, {16'h0, b2, b1});
      wait_busy1(1'b1, 22 * BIT_CLKS, "pair_flush_start");
      wait_busy1(1'b0, 30 * BIT_CLKS, "pair_flush_end");
      check("pair_single_flush", 32'(busy1_rises - b0), 32'd1);
      check("pair_byte_count2_max", 32'(bc2_max), 32'd2);
      check("pair_tx_frames", 32'(tx_frames - f0), 32'd2);

      // Four back-to-back bytes fill the buffer and flush immediately.
      quad = '{8'h11, 8'h22, 8'h33, 8'h44};
      r0 = ready_cnt;
      f0 = tx_frames;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(quad[i]);
         send_byte(quad[i], 1'b1);
      end
      check("quad_ready_pulses", 32'(ready_cnt - r0), 32'd4);
      check("quad_data_store2", data_store2, 32'h4433_2211);
      check("quad_byte_count", 32'(byte_count), 32'd4);
      check("quad_flush_without_idle", 32'({busy1, idle}), 32'b10);
      wait_busy1(1'b0, 50 * BIT_CLKS, "quad_flush_end");
      check("quad_tx_frames", 32'(tx_frames - f0), 32'd4);

      // Short low glitch is rejected as a false start.
      exp_q.push_back(8'h5A);
      send_byte(8'h5A, 1'b1);
      repeat (2 * BIT_CLKS) @(negedge clk);
      r0 = ready_cnt;
      s0 = busy_rises;
      f0 = tx_frames;
      rx = 1'b0;
      repeat (24) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      check("glitch_seen_busy", 32'(busy_rises - s0), 32'd1);
      check("glitch_busy_clear", 32'(busy), 32'd0);
      check("glitch_no_ready", 32'(ready_cnt - r0), 32'd0);
      check("glitch_byte_count", 32'(byte_count), 32'd1);
      wait_busy1(1'b1, 24 * BIT_CLKS, "glitch_flush_start");
      wait_busy1(1'b0, 15 * BIT_CLKS, "glitch_flush_end");
      check("glitch_tx_frames", 32'(tx_frames - f0), 32'd1);

      // Frame with a bad stop bit.
      r0 = ready_cnt;
`ifndef FRAMING_CHECK_EN
      exp_q.push_back(8'h3C);
`endif
      send_byte(8'h3C, 1'b0);
      repeat (2 * BIT_CLKS) @(negedge clk);
      check("badstop_data_store", 32'(data_store), 32'(10'b0_00111100_0));
`ifdef FRAMING_CHECK_EN
      check("badstop_no_ready", 32'(ready_cnt - r0), 32'd0);
      check("badstop_byte_count", 32'(byte_count), 32'd0);
`else
      check("badstop_ready", 32'(ready_cnt - r0), 32'd1);
      check("badstop_byte_count", 32'(byte_count), 32'd1);
      wait_busy1(1'b1, 24 * BIT_CLKS, "badstop_flush_start");
      wait_busy1(1'b0, 15 * BIT_CLKS, "badstop_flush_end");
`endif

      repeat (BIT_CLKS) @(negedge clk);
      check("end_tx_idle", 32'(tx), 32'd1);
      check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
